// File: rtl/aes_mini_pkg.sv
// Shared geometry, state typedef, FSM encoding and cell packing helper for the
// mini-AES round-key datapath.
package aes_mini_pkg;

    localparam int DIM     = 2;
    localparam int CELL_W  = 2;
    localparam int STATE_W = DIM * DIM * CELL_W;

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fsm_t;

    // Slot of 1-based cell (r,c); cell (1,1) sits in the most significant slot
    // and cells are packed column by column.
    function automatic int cell_slot(input int r, input int c, input int dim = DIM);
        return dim * dim - 1 - (dim * (c - 1) + (r - 1));
    endfunction

endpackage

// File: rtl/mini_shift_rows.sv
// Combinational ShiftRows: row r of the DIM x DIM state rotates left by r-1
// columns. Pure wiring.
module mini_shift_rows #(
    parameter int DIM    = 2,
    parameter int CELL_W = 2
) (
    input  logic [DIM*DIM*CELL_W-1:0] st_in,
    output logic [DIM*DIM*CELL_W-1:0] st_out
);

    for (genvar r = 1; r <= DIM; r++) begin : g_row
        for (genvar c = 1; c <= DIM; c++) begin : g_col
            localparam int SRC_C = ((c - 1) + (r - 1)) % DIM + 1;
            localparam int DST_SLOT = aes_mini_pkg::cell_slot(r, c, DIM);
            localparam int SRC_SLOT = aes_mini_pkg::cell_slot(r, SRC_C, DIM);

            assign st_out[DST_SLOT*CELL_W +: CELL_W] = st_in[SRC_SLOT*CELL_W +: CELL_W];
        end
    end

endmodule

// File: rtl/ark_round_sequencer.sv
// Runs key whitening plus NUM_ROUNDS AddRoundKey rounds over one state block,
// fetching each round key from the key store over a req/valid handshake.
module ark_round_sequencer #(
    parameter int  DIM        = 2,
    parameter int  CELL_W     = 2,
    parameter int  NUM_ROUNDS = 2,
    parameter int  SHIFT_EN   = 1,
    localparam int STATE_W    = DIM * DIM * CELL_W,
    localparam int IDX_W      = (NUM_ROUNDS > 0) ? $clog2(NUM_ROUNDS + 1) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               key_req,
    output logic [IDX_W-1:0]   key_idx,
    input  logic               key_valid,
    input  logic [STATE_W-1:0] key_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    input  logic               abort,
    output logic               busy
);

    import aes_mini_pkg::fsm_t;
    import aes_mini_pkg::IDLE;
    import aes_mini_pkg::FETCH;
    import aes_mini_pkg::DONE;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    fsm_t               state;
    logic [STATE_W-1:0] st;
    logic [STATE_W-1:0] st_shifted;
    logic [STATE_W-1:0] st_next;

    mini_shift_rows #(
        .DIM    (DIM),
        .CELL_W (CELL_W)
    ) u_shift_rows (
        .st_in  (st),
        .st_out (st_shifted)
    );

    // Round 0 is plain key whitening; later rounds optionally ShiftRows first.
    assign st_next = (((SHIFT_EN != 0) && (key_idx != '0)) ? st_shifted : st) ^ key_data;

    // NOTE: every register below uses <= so all of them update from the same
    // pre-edge values; a blocking = here would let later lines see new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st        <= '0;
            in_ready  <= 1'b1;
            key_req   <= 1'b0;
            key_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            key_req   <= 1'b0;
            key_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_data;
                        key_idx  <= '0;
                        key_req  <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (key_valid) begin
                        st <= st_next;
                        if (key_idx == LAST_IDX) begin
                            key_req   <= 1'b0;
                            out_data  <= st_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            key_idx <= key_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ark_round_sequencer.sv
// Bench for ark_round_sequencer: directed scenarios plus randomized blocks,
// all checked every cycle against a cell-array model of the round sequence.
module tb_ark_round_sequencer;

    import aes_mini_pkg::state_t;

    localparam int NUM_ROUNDS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    state_t     in_data = '0;
    logic       key_req;
    logic [1:0] key_idx;
    logic       key_valid = 1'b0;
    state_t     key_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    state_t     out_data;
    logic       abort = 1'b0;
    logic       busy;

    logic       ns_in_valid = 1'b0;
    logic       ns_in_ready;
    state_t     ns_in_data = '0;
    logic       ns_key_req;
    logic [1:0] ns_key_idx;
    logic       ns_key_valid = 1'b0;
    state_t     ns_key_data = '0;
    logic       ns_out_valid;
    state_t     ns_out_data;
    logic       ns_busy;

    ark_round_sequencer #(.DIM(2), .CELL_W(2), .NUM_ROUNDS(NUM_ROUNDS), .SHIFT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_req(key_req), .key_idx(key_idx), .key_valid(key_valid), .key_data(key_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .abort(abort), .busy(busy)
    );

    ark_round_sequencer #(.DIM(2), .CELL_W(2), .NUM_ROUNDS(NUM_ROUNDS), .SHIFT_EN(0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data),
        .key_req(ns_key_req), .key_idx(ns_key_idx), .key_valid(ns_key_valid), .key_data(ns_key_data),
        .out_valid(ns_out_valid), .out_ready(1'b0), .out_data(ns_out_data),
        .abort(1'b0), .busy(ns_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Reference: unpack to a 2x2 cell grid (cell (r,c) 0-based in slot 3-(2c+r)),
    // rotate row r left by r for rounds >= 1, XOR the key cells, repack.
    function automatic state_t ark_model(input state_t blk, input state_t k [3], input bit sh);
        logic [1:0] cl [2][2];
        logic [1:0] t  [2][2];
        state_t     res;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                cl[r][c] = blk[(3 - (2 * c + r)) * 2 +: 2];
        for (int rd = 0; rd <= NUM_ROUNDS; rd++) begin
            if (rd > 0 && sh) begin
                t = cl;
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++)
                        cl[r][c] = t[r][(c + r) % 2];
            end
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    cl[r][c] = cl[r][c] ^ k[rd][(3 - (2 * c + r)) * 2 +: 2];
        end
        res = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                res[(3 - (2 * c + r)) * 2 +: 2] = cl[r][c];
        return res;
    endfunction

    // Key-store agent settings and the keys served for the current block.
    state_t keys_a [3];
    state_t ns_keys [3];
    int     key_delay = 0;
    bit     key_rand  = 1'b0;

    // Model of the block in flight.
    bit     m_idle = 1'b1;
    bit     m_fetch = 1'b0;
    bit     m_done = 1'b0;
    int     m_idx = 0;
    state_t m_out = '0;
    int     m_lat = 0;
    int     m_stalls = 0;

    int     cyc = 0;
    int     acc_cyc = 0;
    int     out_cyc = 0;
    int     out_events = 0;
    logic   prev_ov = 1'b0;
    int     wait_cnt = 0;
    int     cur_delay = 0;
    bit     hs_prev = 1'b0;

    // Single compare process: checks outputs, plays the key store, then advances
    // the model with the inputs the next rising edge will sample.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_key_req", key_req, 1'b0);
            check("rst_key_idx", key_idx, 2'd0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_data", out_data, 8'h00);
            check("rst_busy", busy, 1'b0);
            m_idle = 1'b1; m_fetch = 1'b0; m_done = 1'b0; m_idx = 0;
            key_valid = 1'b0;
            hs_prev = 1'b0;
            prev_ov = 1'b0;
        end else begin
            m_lat++;
            check("in_ready", in_ready, m_idle);
            check("busy", busy, !m_idle);
            check("key_req", key_req, m_fetch);
            check("out_valid", out_valid, m_done);
            if (m_fetch) check("key_idx", key_idx, m_idx);
            if (m_done) begin
                check("out_data", out_data, m_out);
                if (!prev_ov) begin
                    check("latency", m_lat, NUM_ROUNDS + 2 + m_stalls);
                    out_events++;
                    out_cyc = cyc;
                end
            end
            prev_ov = out_valid;

            if (!key_req || hs_prev) begin
                wait_cnt  = 0;
                cur_delay = key_rand ? int'($urandom_range(0, 3)) : key_delay;
            end
            hs_prev = 1'b0;
            if (key_req && wait_cnt >= cur_delay && key_idx <= 2'd2) begin
                key_valid = 1'b1;
                key_data  = keys_a[key_idx];
                hs_prev   = 1'b1;
            end else begin
                key_valid = 1'b0;
                key_data  = state_t'($urandom);
                if (key_req) wait_cnt++;
            end

            if (abort) begin
                m_idle = 1'b1; m_fetch = 1'b0; m_done = 1'b0; m_idx = 0;
            end else if (m_idle) begin
                if (in_valid) begin
                    m_out = ark_model(in_data, keys_a, 1'b1);
                    m_idle = 1'b0; m_fetch = 1'b1; m_idx = 0;
                    m_lat = 0; m_stalls = 0;
                    acc_cyc = cyc;
                end
            end else if (m_fetch) begin
                if (key_valid) begin
                    if (m_idx == NUM_ROUNDS) begin
                        m_fetch = 1'b0;
                        m_done  = 1'b1;
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_stalls++;
                end
            end else if (m_done && out_ready) begin
                m_done = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    // Zero-wait key store for the SHIFT_EN=0 instance.
    always @(negedge clk) begin
        ns_key_valid = ns_key_req;
        ns_key_data  = (ns_key_idx <= 2'd2) ? ns_keys[ns_key_idx] : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input state_t blk);
        bit ok;
        ok = 1'b0;
        in_data  = blk;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) timeout_fail("send_accept");
    endtask

    task automatic wait_out(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic release_out(input int hold);
        tick();
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic set_keys(input state_t k0, input state_t k1, input state_t k2);
        keys_a[0] = k0;
        keys_a[1] = k1;
        keys_a[2] = k2;
    endtask

    initial begin
        int ev0;
        bit ok;
        set_keys(8'h00, 8'h00, 8'h00);
        ns_keys[0] = 8'h0F; ns_keys[1] = 8'hF0; ns_keys[2] = 8'h33;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // SHIFT_EN=0 instance: plain XOR chain A5^0F^F0^33 = 69.
        ns_in_data  = 8'hA5;
        ns_in_valid = 1'b1;
        tick();
        ns_in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (ns_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("ns_out");
        check("ns_literal", ns_out_data, 8'h69);
        check("ns_model", ns_out_data, ark_model(8'hA5, ns_keys, 1'b0));
        tick();

        // Test 1: zero-wait keys.
        set_keys(8'h1F, 8'h00, 8'hFF);
        key_delay = 0;
        send(8'hFB);
        wait_out("t1_out", 30);
        check("t1_data", out_data, 8'h1B);
        check("t1_latency", out_cyc - acc_cyc, 4);
        release_out(0);

        // Test 2: all-zero keys, double ShiftRows is identity.
        set_keys(8'h00, 8'h00, 8'h00);
        send(8'hA5);
        wait_out("t2_out", 30);
        check("t2_data", out_data, 8'hA5);
        release_out(0);

        // Test 3: three stall cycles per key request.
        set_keys(8'h1F, 8'h00, 8'hFF);
        key_delay = 3;
        send(8'hFB);
        wait_out("t3_out", 60);
        check("t3_data", out_data, 8'h1B);
        check("t3_latency", out_cyc - acc_cyc, 13);

        // Test 4: downstream back-pressure in DONE.
        tick();
        repeat (5) tick();
        check("t4_valid_held", out_valid, 1'b1);
        check("t4_data_held", out_data, 8'h1B);
        check("t4_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_in_ready_back", in_ready, 1'b1);
        check("t4_valid_drop", out_valid, 1'b0);

        // Test 5: abort lands together with the round-1 key.
        key_delay = 0;
        ev0 = out_events;
        send(8'hFB);
        tick();
        check("t5_idx_before", key_idx, 2'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_key_req", key_req, 1'b0);
        check("t5_key_idx", key_idx, 2'd0);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_in_ready", in_ready, 1'b1);
        repeat (6) tick();
        check("t5_no_result", out_events, ev0);
        send(8'hFB);
        wait_out("t5_out", 30);
        check("t5_next_data", out_data, 8'h1B);
        release_out(0);

        // Test 6a: async reset in the middle of FETCH.
        key_delay = 3;
        send(8'hFB);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_key_req", key_req, 1'b0);
        check("t6_rst_in_ready", in_ready, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_out_data", out_data, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Test 6b: in_valid offered while FETCH is running is dropped.
        key_delay = 1;
        ev0 = out_events;
        send(8'hFB);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        wait_out("t6_out", 40);
        check("t6_data", out_data, 8'h1B);
        release_out(1);
        repeat (8) tick();
        check("t6_one_result", out_events - ev0, 1);

        // Randomized blocks with random key stalls, back-pressure and aborts.
        key_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            set_keys(state_t'($urandom), state_t'($urandom), state_t'($urandom));
            send(state_t'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 4)) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                tick();
            end else begin
                wait_out("rand_out", 60);
                release_out($urandom_range(0, 3));
            end
        end
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
